tof_result_arbiter: RTL and testbench
=====================================

# tof_result_arbiter

Collects distance results from NB_OF_SENSORS per-sensor ToF FSMs and serialises them onto one valid/ready result stream. Each channel has a one-deep capture slot. Channels are arbitrated either round-robin or by fixed priority (highest index wins). Overruns are flagged per channel, and the newest data always wins. The block sits between the per-sensor ToF FSM array and the result consumer (UART/AXI bridge), and replaces the sticky-ready plus priority-index scheme.

## Interface
Parameters:
- NB_OF_SENSORS, 8: number of channels, 2..16.
- DIST_W, 16: distance width in mm.
- ZONE_W, 6: zone/sensor_index width.
- CH_W, $clog2(NB_OF_SENSORS): channel index width.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (highest index first).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- data_ready  in  NB_OF_SENSORS  one-cycle pulse per channel; new result present.
- distance_data  in  NB_OF_SENSORS*DIST_W  channel i occupies bits [i*DIST_W +: DIST_W].
- zone_index  in  NB_OF_SENSORS*ZONE_W  channel i occupies bits [i*ZONE_W +: ZONE_W].
- out_valid  out  1  result available on out_*.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_channel  out  CH_W  source channel of the current result.
- out_zone  out  ZONE_W  zone of the current result.
- out_distance  out  DIST_W  distance of the current result.
- pending  out  NB_OF_SENSORS  slot i holds unsent data.
- overrun  out  NB_OF_SENSORS  sticky; slot i was overwritten before it was sent.
- overrun_clr  in  NB_OF_SENSORS  one-cycle pulse; clears the matching overrun bits.

## Operation
- Capture slot i: when data_ready[i]=1, latch distance and zone into slot i and set pending[i].
- If pending[i] is already 1 and slot i is not being granted this cycle, the slot is overwritten and overrun[i] is set.
- Output register load condition: load = !out_valid || out_ready. Accepting a result and loading the next one happen in the same cycle (no bubble).
- When load is true and any pending bit is 1:
  - The arbiter selects channel g.
  - Slot g is copied to out_*, out_channel is set to g, and out_valid is set to 1.
  - pending[g] is cleared.
- When load is true and no pending bit is 1, out_valid goes to 0.
- Grant and capture in the same cycle on channel g: pending[g] stays 1 and the slot takes the new data. The old data goes to the output. No overrun is flagged.
- Round-robin (ARB_MODE=0):
  - Search starts at last_grant+1 and wraps modulo NB_OF_SENSORS.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NB_OF_SENSORS-1, so channel 0 has first priority.
- Fixed priority (ARB_MODE=1): the highest pending index wins. last_grant is unused.
- Overrun set and overrun_clr on the same bit in the same cycle: set wins.
- The arbiter uses registered pending, so a channel captured in cycle n is eligible from cycle n+1.
- State: the block has two output states, EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL: any pending bit set.
  - FULL -> EMPTY: out_ready=1 and no pending bits.
  - FULL -> FULL: no accept, or accept with refill.

## Timing
- Reset (reset=0 at a posedge): out_valid, out_channel, out_zone, out_distance, pending, overrun and all slots go to 0. last_grant goes to NB_OF_SENSORS-1.
- Reset has priority over every input in the same cycle. A reset mid-transfer drops the held result and all pending results.
- Latency with output empty: data_ready[i] at edge n gives pending[i]=1 after edge n, and out_valid=1 with the data after edge n+1.
- Throughput: one result per cycle while out_ready=1 and pending is non-empty.
- While out_valid=1 && out_ready=0, out_* hold stable.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then single capture: data_ready[3] with distance 0x01F4 and zone 5. Required: out_valid=1 two edges later, out_channel=3, out_distance=0x01F4, out_zone=5. pending[3] is 0 after the grant.
- Round-robin fairness: ARB_MODE=0, all 8 channels pulse at once, out_ready=1. Required: out_channel sequence 0,1,2,...,7 on consecutive cycles, then out_valid=0.
- Fixed priority: ARB_MODE=1, channels 2 and 6 pulse together. Required: channel 6 is output first, then channel 2.
- Overrun: out_ready=0 with the output holding channel 0. Channel 1 captures 100, then 200. Required: overrun[1]=1. When out_ready=1, channel 1 outputs 200. overrun_clr[1] pulse clears the bit.
- Backpressure and grant/capture collision: out_ready toggles 0/1 while channel 4 receives data_ready exactly on its grant cycle. Required: out_* stable while stalled, the old value is emitted, the new value is emitted next, and overrun[4]=0.
- Mid-stream reset: 5 channels pending and out_valid=1, then reset=0 for 1 cycle. Required: all outputs 0 on the next cycle. After release, the first grant goes to channel 0.

Source files
------------

// File: rtl/tof_result_arbiter.sv
// Collects results from per-sensor ToF FSMs into one-deep slots and serialises
// them onto a single valid/ready stream, round-robin or highest-index-first.
module tof_result_arbiter #(
    parameter int NB_OF_SENSORS = 8,
    parameter int DIST_W        = 16,
    parameter int ZONE_W        = 6,
    parameter int CH_W          = $clog2(NB_OF_SENSORS),
    parameter int ARB_MODE      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NB_OF_SENSORS-1:0]        data_ready,
    input  logic [NB_OF_SENSORS*DIST_W-1:0] distance_data,
    input  logic [NB_OF_SENSORS*ZONE_W-1:0] zone_index,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CH_W-1:0]                 out_channel,
    output logic [ZONE_W-1:0]               out_zone,
    output logic [DIST_W-1:0]               out_distance,
    output logic [NB_OF_SENSORS-1:0]        pending,
    output logic [NB_OF_SENSORS-1:0]        overrun,
    input  logic [NB_OF_SENSORS-1:0]        overrun_clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_e;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NB_OF_SENSORS - 1);
    localparam logic [CH_W:0]   NB_EXT  = (CH_W+1)'(NB_OF_SENSORS);

    outState_e                  state_q, state_d;
    logic [NB_OF_SENSORS-1:0]   pending_q, pending_d;
    logic [NB_OF_SENSORS-1:0]   overrun_q, overrun_d;
    logic [DIST_W-1:0]          slotDist_q [NB_OF_SENSORS];
    logic [ZONE_W-1:0]          slotZone_q [NB_OF_SENSORS];
    logic [CH_W-1:0]            lastGrant_q, lastGrant_d;
    logic [CH_W-1:0]            outChannel_q, outChannel_d;
    logic [ZONE_W-1:0]          outZone_q, outZone_d;
    logic [DIST_W-1:0]          outDist_q, outDist_d;

    logic                       load;
    logic                       anyPending;
    logic                       grantValid;
    logic [CH_W-1:0]            grantIdx;
    logic [NB_OF_SENSORS-1:0]   grantOneHot;

    assign load       = (state_q == EMPTY) || out_ready;
    assign anyPending = |pending_q;
    assign grantValid = load && anyPending;

    // Later loop iterations override earlier ones, so the last match is the winner:
    // ascending index for fixed priority, descending distance from last_grant for RR.
    always_comb begin : arbiter
        logic [CH_W:0] idx;
        grantIdx = '0;
        idx      = '0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NB_OF_SENSORS; i++) begin
                if (pending_q[i]) begin
                    grantIdx = CH_W'(i);
                end
            end
        end else begin
            for (int k = NB_OF_SENSORS; k >= 1; k--) begin
                idx = {1'b0, lastGrant_q} + (CH_W+1)'(k);
                if (idx >= NB_EXT) begin
                    idx = idx - NB_EXT;
                end
                if (pending_q[idx[CH_W-1:0]]) begin
                    grantIdx = idx[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        grantOneHot = '0;
        if (grantValid) begin
            grantOneHot[grantIdx] = 1'b1;
        end
    end

    // A slot captured on its own grant cycle stays pending with the new data,
    // while the old contents go to the output; that is not an overrun.
    always_comb begin : nextState
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        outChannel_d = outChannel_q;
        outZone_d    = outZone_q;
        outDist_d    = outDist_q;
        if (grantValid) begin
            state_d      = FULL;
            lastGrant_d  = grantIdx;
            outChannel_d = grantIdx;
            outZone_d    = slotZone_q[grantIdx];
            outDist_d    = slotDist_q[grantIdx];
        end else if (load) begin
            state_d = EMPTY;
        end
        pending_d = (pending_q & ~grantOneHot) | data_ready;
        overrun_d = (overrun_q & ~overrun_clr) | (data_ready & pending_q & ~grantOneHot);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= EMPTY;
            pending_q    <= '0;
            overrun_q    <= '0;
            lastGrant_q  <= LAST_CH;
            outChannel_q <= '0;
            outZone_q    <= '0;
            outDist_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            lastGrant_q  <= lastGrant_d;
            outChannel_q <= outChannel_d;
            outZone_q    <= outZone_d;
            outDist_q    <= outDist_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_OF_SENSORS; i++) begin
            if (!reset) begin
                slotDist_q[i] <= '0;
                slotZone_q[i] <= '0;
            end else if (data_ready[i]) begin
                slotDist_q[i] <= distance_data[i*DIST_W +: DIST_W];
                slotZone_q[i] <= zone_index[i*ZONE_W +: ZONE_W];
            end
        end
    end

    assign out_valid    = (state_q == FULL);
    assign out_channel  = outChannel_q;
    assign out_zone     = outZone_q;
    assign out_distance = outDist_q;
    assign pending      = pending_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tof_result_arbiter.sv
// Drives a round-robin and a fixed-priority instance with shared stimulus and
// checks both against directed expectations and a per-mode behavioural model.
module tb_tof_result_arbiter;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int ZW = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   dataReady;
    logic [N*DW-1:0] distanceData;
    logic [N*ZW-1:0] zoneIndex;
    logic           outReady;
    logic [N-1:0]   overrunClr;

    logic           dutValid   [2];
    logic [2:0]     dutChannel [2];
    logic [ZW-1:0]  dutZone    [2];
    logic [DW-1:0]  dutDist    [2];
    logic [N-1:0]   dutPending [2];
    logic [N-1:0]   dutOverrun [2];

    // Model state, index 0 = round-robin instance, 1 = fixed priority
    logic [DW-1:0]  mDist  [2][N];
    logic [ZW-1:0]  mZone  [2][N];
    logic [N-1:0]   mPend  [2];
    logic [N-1:0]   mOvr   [2];
    int             mLast  [2];
    logic           mValid [2];
    logic [2:0]     mCh    [2];
    logic [ZW-1:0]  mOutZ  [2];
    logic [DW-1:0]  mOutD  [2];

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    tof_result_arbiter #(.NB_OF_SENSORS(N), .DIST_W(DW), .ZONE_W(ZW), .ARB_MODE(0)) dutRr (
        .clk(clk), .reset(reset), .data_ready(dataReady), .distance_data(distanceData),
        .zone_index(zoneIndex), .out_valid(dutValid[0]), .out_ready(outReady),
        .out_channel(dutChannel[0]), .out_zone(dutZone[0]), .out_distance(dutDist[0]),
        .pending(dutPending[0]), .overrun(dutOverrun[0]), .overrun_clr(overrunClr)
    );

    tof_result_arbiter #(.NB_OF_SENSORS(N), .DIST_W(DW), .ZONE_W(ZW), .ARB_MODE(1)) dutFp (
        .clk(clk), .reset(reset), .data_ready(dataReady), .distance_data(distanceData),
        .zone_index(zoneIndex), .out_valid(dutValid[1]), .out_ready(outReady),
        .out_channel(dutChannel[1]), .out_zone(dutZone[1]), .out_distance(dutDist[1]),
        .pending(dutPending[1]), .overrun(dutOverrun[1]), .overrun_clr(overrunClr)
    );

    // One clock of the reference behaviour, evaluated on the inputs about to be sampled
    task automatic modelStep(input int m);
        int  g;
        int  c;
        bit  load;
        if (reset === 1'b0) begin
            mPend[m] = '0; mOvr[m] = '0; mValid[m] = 1'b0; mCh[m] = '0;
            mOutZ[m] = '0; mOutD[m] = '0; mLast[m] = N - 1;
            for (int i = 0; i < N; i++) begin
                mDist[m][i] = '0;
                mZone[m][i] = '0;
            end
            return;
        end
        load = !mValid[m] || (outReady === 1'b1);
        g = -1;
        if (load) begin
            for (int k = 1; k <= N; k++) begin
                c = (m == 0) ? (mLast[m] + k) % N : N - k;
                if (g < 0 && mPend[m][c]) g = c;
            end
        end
        if (g >= 0) begin
            mValid[m] = 1'b1;
            mCh[m]    = 3'(g);
            mOutZ[m]  = mZone[m][g];
            mOutD[m]  = mDist[m][g];
            mLast[m]  = g;
        end else if (load) begin
            mValid[m] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (overrunClr[i]) mOvr[m][i] = 1'b0;
            if (dataReady[i]) begin
                if (mPend[m][i] && i != g) mOvr[m][i] = 1'b1;
                mPend[m][i] = 1'b1;
                mDist[m][i] = distanceData[i*DW +: DW];
                mZone[m][i] = zoneIndex[i*ZW +: ZW];
            end else if (i == g) begin
                mPend[m][i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic [DW-1:0] d, input logic [ZW-1:0] z);
        dataReady[ch] = 1'b1;
        distanceData[ch*DW +: DW] = d;
        zoneIndex[ch*ZW +: ZW] = z;
    endtask

    task automatic clearPulses();
        dataReady  = '0;
        overrunClr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; outReady = 1'b0; clearPulses();
        tick(); tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid dut%0d got %0b want 0", m, dutValid[m]); end
            vectorCount++; if (dutChannel[m] !== 3'd0) begin missCount++; $display("[TB] FAIL reset_channel dut%0d got %0d want 0", m, dutChannel[m]); end
            vectorCount++; if (dutDist[m] !== 16'd0) begin missCount++; $display("[TB] FAIL reset_dist dut%0d got %0h want 0", m, dutDist[m]); end
            vectorCount++; if (dutZone[m] !== 6'd0) begin missCount++; $display("[TB] FAIL reset_zone dut%0d got %0d want 0", m, dutZone[m]); end
            vectorCount++; if (dutPending[m] !== 8'd0) begin missCount++; $display("[TB] FAIL reset_pending dut%0d got %0h want 0", m, dutPending[m]); end
            vectorCount++; if (dutOverrun[m] !== 8'd0) begin missCount++; $display("[TB] FAIL reset_overrun dut%0d got %0h want 0", m, dutOverrun[m]); end
        end
        reset = 1'b1;
    endtask

    task automatic test_single_capture();
        outReady = 1'b0;
        applyStimulus(3, 16'h01F4, 6'd5);
        tick(); clearPulses();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutPending[m][3] !== 1'b1) begin missCount++; $display("[TB] FAIL single_pending_set dut%0d got %0b want 1", m, dutPending[m][3]); end
            vectorCount++; if (dutValid[m] !== 1'b0) begin missCount++; $display("[TB] FAIL single_early_valid dut%0d got %0b want 0", m, dutValid[m]); end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b1) begin missCount++; $display("[TB] FAIL single_valid dut%0d got %0b want 1", m, dutValid[m]); end
            vectorCount++; if (dutChannel[m] !== 3'd3) begin missCount++; $display("[TB] FAIL single_channel dut%0d got %0d want 3", m, dutChannel[m]); end
            vectorCount++; if (dutDist[m] !== 16'h01F4) begin missCount++; $display("[TB] FAIL single_dist dut%0d got %0h want 1f4", m, dutDist[m]); end
            vectorCount++; if (dutZone[m] !== 6'd5) begin missCount++; $display("[TB] FAIL single_zone dut%0d got %0d want 5", m, dutZone[m]); end
            vectorCount++; if (dutPending[m][3] !== 1'b0) begin missCount++; $display("[TB] FAIL single_pending_clr dut%0d got %0b want 0", m, dutPending[m][3]); end
        end
        outReady = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b0) begin missCount++; $display("[TB] FAIL single_drain dut%0d got %0b want 0", m, dutValid[m]); end
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b0; tick(); reset = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < N; i++) applyStimulus(i, 16'(16'h0100 + i), 6'(i + 10));
        tick(); clearPulses();
        for (int k = 0; k < N; k++) begin
            tick();
            vectorCount++; if (dutValid[0] !== 1'b1 || dutChannel[0] !== 3'(k)) begin missCount++; $display("[TB] FAIL rr_order step %0d got v=%0b ch=%0d want v=1 ch=%0d", k, dutValid[0], dutChannel[0], k); end
            vectorCount++; if (dutDist[0] !== 16'(16'h0100 + k)) begin missCount++; $display("[TB] FAIL rr_dist step %0d got %0h want %0h", k, dutDist[0], 16'h0100 + k); end
            vectorCount++; if (dutValid[1] !== 1'b1 || dutChannel[1] !== 3'(N - 1 - k)) begin missCount++; $display("[TB] FAIL fp_order step %0d got v=%0b ch=%0d want v=1 ch=%0d", k, dutValid[1], dutChannel[1], N - 1 - k); end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b0) begin missCount++; $display("[TB] FAIL rr_drain dut%0d got %0b want 0", m, dutValid[m]); end
        end
    endtask

    task automatic test_fixed_priority();
        outReady = 1'b1;
        applyStimulus(2, 16'h0222, 6'd2);
        applyStimulus(6, 16'h0666, 6'd6);
        tick(); clearPulses();
        tick();
        vectorCount++; if (dutChannel[1] !== 3'd6 || dutDist[1] !== 16'h0666) begin missCount++; $display("[TB] FAIL fp_first got ch=%0d d=%0h want ch=6 d=666", dutChannel[1], dutDist[1]); end
        vectorCount++; if (dutChannel[0] !== 3'd2) begin missCount++; $display("[TB] FAIL rr_first got ch=%0d want 2", dutChannel[0]); end
        tick();
        vectorCount++; if (dutChannel[1] !== 3'd2 || dutDist[1] !== 16'h0222) begin missCount++; $display("[TB] FAIL fp_second got ch=%0d d=%0h want ch=2 d=222", dutChannel[1], dutDist[1]); end
        vectorCount++; if (dutChannel[0] !== 3'd6) begin missCount++; $display("[TB] FAIL rr_second got ch=%0d want 6", dutChannel[0]); end
        tick();
    endtask

    task automatic test_overrun();
        outReady = 1'b0;
        applyStimulus(0, 16'd50, 6'd1); tick(); clearPulses();
        tick();
        applyStimulus(1, 16'd100, 6'd2); tick(); clearPulses();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutOverrun[m][1] !== 1'b0) begin missCount++; $display("[TB] FAIL ovr_early dut%0d got %0b want 0", m, dutOverrun[m][1]); end
        end
        applyStimulus(1, 16'd200, 6'd3); tick(); clearPulses();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutOverrun[m] !== 8'h02) begin missCount++; $display("[TB] FAIL ovr_set dut%0d got %0h want 02", m, dutOverrun[m]); end
            vectorCount++; if (dutChannel[m] !== 3'd0 || dutDist[m] !== 16'd50) begin missCount++; $display("[TB] FAIL ovr_hold dut%0d got ch=%0d d=%0d want ch=0 d=50", m, dutChannel[m], dutDist[m]); end
        end
        outReady = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutChannel[m] !== 3'd1 || dutDist[m] !== 16'd200 || dutValid[m] !== 1'b1) begin missCount++; $display("[TB] FAIL ovr_newest dut%0d got ch=%0d d=%0d want ch=1 d=200", m, dutChannel[m], dutDist[m]); end
        end
        overrunClr[1] = 1'b1; tick(); clearPulses();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutOverrun[m][1] !== 1'b0) begin missCount++; $display("[TB] FAIL ovr_clear dut%0d got %0b want 0", m, dutOverrun[m][1]); end
        end
        // Set and clear on the same bit in the same cycle: set must win
        outReady = 1'b0;
        applyStimulus(1, 16'd11, 6'd1); tick(); clearPulses();
        tick();
        applyStimulus(1, 16'd12, 6'd1); tick(); clearPulses();
        applyStimulus(1, 16'd13, 6'd1); overrunClr[1] = 1'b1; tick(); clearPulses();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutOverrun[m][1] !== 1'b1) begin missCount++; $display("[TB] FAIL ovr_set_wins dut%0d got %0b want 1", m, dutOverrun[m][1]); end
        end
        overrunClr[1] = 1'b1; outReady = 1'b1; tick(); clearPulses();
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        reset = 1'b0; tick(); reset = 1'b1;
        outReady = 1'b1;
        applyStimulus(4, 16'h0444, 6'd4); tick(); clearPulses();
        applyStimulus(4, 16'h0888, 6'd8); tick(); clearPulses();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b1 || dutChannel[m] !== 3'd4 || dutDist[m] !== 16'h0444) begin missCount++; $display("[TB] FAIL coll_old dut%0d got v=%0b ch=%0d d=%0h want v=1 ch=4 d=444", m, dutValid[m], dutChannel[m], dutDist[m]); end
            vectorCount++; if (dutPending[m][4] !== 1'b1) begin missCount++; $display("[TB] FAIL coll_pending dut%0d got %0b want 1", m, dutPending[m][4]); end
        end
        outReady = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                vectorCount++; if (dutValid[m] !== 1'b1 || dutDist[m] !== 16'h0444 || dutZone[m] !== 6'd4) begin missCount++; $display("[TB] FAIL coll_stall dut%0d got v=%0b d=%0h z=%0d want v=1 d=444 z=4", m, dutValid[m], dutDist[m], dutZone[m]); end
            end
        end
        outReady = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutChannel[m] !== 3'd4 || dutDist[m] !== 16'h0888 || dutZone[m] !== 6'd8) begin missCount++; $display("[TB] FAIL coll_new dut%0d got ch=%0d d=%0h want ch=4 d=888", m, dutChannel[m], dutDist[m]); end
            vectorCount++; if (dutOverrun[m][4] !== 1'b0) begin missCount++; $display("[TB] FAIL coll_overrun dut%0d got %0b want 0", m, dutOverrun[m][4]); end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b0) begin missCount++; $display("[TB] FAIL coll_drain dut%0d got %0b want 0", m, dutValid[m]); end
        end
    endtask

    task automatic test_midstream_reset();
        outReady = 1'b0;
        applyStimulus(1, 16'd1, 6'd1); applyStimulus(2, 16'd2, 6'd2); applyStimulus(3, 16'd3, 6'd3);
        applyStimulus(5, 16'd5, 6'd5); applyStimulus(6, 16'd6, 6'd6);
        tick(); clearPulses();
        tick();
        vectorCount++; if (dutValid[0] !== 1'b1 || dutChannel[0] !== 3'd5) begin missCount++; $display("[TB] FAIL mid_pre_rr got v=%0b ch=%0d want v=1 ch=5", dutValid[0], dutChannel[0]); end
        vectorCount++; if (dutValid[1] !== 1'b1 || dutChannel[1] !== 3'd6) begin missCount++; $display("[TB] FAIL mid_pre_fp got v=%0b ch=%0d want v=1 ch=6", dutValid[1], dutChannel[1]); end
        reset = 1'b0; outReady = 1'b1;
        tick();
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            vectorCount++; if (dutValid[m] !== 1'b0 || dutChannel[m] !== 3'd0 || dutDist[m] !== 16'd0 || dutZone[m] !== 6'd0) begin missCount++; $display("[TB] FAIL mid_out_zero dut%0d got v=%0b ch=%0d d=%0h z=%0d want all 0", m, dutValid[m], dutChannel[m], dutDist[m], dutZone[m]); end
            vectorCount++; if (dutPending[m] !== 8'd0 || dutOverrun[m] !== 8'd0) begin missCount++; $display("[TB] FAIL mid_flags_zero dut%0d got p=%0h o=%0h want 0", m, dutPending[m], dutOverrun[m]); end
        end
        applyStimulus(0, 16'h00A0, 6'd9); applyStimulus(3, 16'h00A3, 6'd9);
        tick(); clearPulses();
        tick();
        vectorCount++; if (dutChannel[0] !== 3'd0 || dutDist[0] !== 16'h00A0) begin missCount++; $display("[TB] FAIL mid_first_rr got ch=%0d d=%0h want ch=0 d=a0", dutChannel[0], dutDist[0]); end
        vectorCount++; if (dutChannel[1] !== 3'd3 || dutDist[1] !== 16'h00A3) begin missCount++; $display("[TB] FAIL mid_first_fp got ch=%0d d=%0h want ch=3 d=a3", dutChannel[1], dutDist[1]); end
        tick(); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                dataReady[i] = ($urandom_range(0, 3) == 0);
                distanceData[i*DW +: DW] = 16'($urandom);
                zoneIndex[i*ZW +: ZW] = 6'($urandom);
                overrunClr[i] = ($urandom_range(0, 9) == 0);
            end
            outReady = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 79) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                vectorCount++; if (dutValid[m] !== mValid[m]) begin missCount++; $display("[TB] FAIL rand_valid dut%0d cyc %0d got %0b want %0b", m, n, dutValid[m], mValid[m]); end
                vectorCount++; if (dutChannel[m] !== mCh[m]) begin missCount++; $display("[TB] FAIL rand_channel dut%0d cyc %0d got %0d want %0d", m, n, dutChannel[m], mCh[m]); end
                vectorCount++; if (dutDist[m] !== mOutD[m]) begin missCount++; $display("[TB] FAIL rand_dist dut%0d cyc %0d got %0h want %0h", m, n, dutDist[m], mOutD[m]); end
                vectorCount++; if (dutZone[m] !== mOutZ[m]) begin missCount++; $display("[TB] FAIL rand_zone dut%0d cyc %0d got %0d want %0d", m, n, dutZone[m], mOutZ[m]); end
                vectorCount++; if (dutPending[m] !== mPend[m]) begin missCount++; $display("[TB] FAIL rand_pending dut%0d cyc %0d got %0h want %0h", m, n, dutPending[m], mPend[m]); end
                vectorCount++; if (dutOverrun[m] !== mOvr[m]) begin missCount++; $display("[TB] FAIL rand_overrun dut%0d cyc %0d got %0h want %0h", m, n, dutOverrun[m], mOvr[m]); end
            end
        end
        clearPulses();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        outReady     = 1'b0;
        dataReady    = '0;
        overrunClr   = '0;
        distanceData = '0;
        zoneIndex    = '0;
        test_reset();
        test_single_capture();
        test_round_robin();
        test_fixed_priority();
        test_overrun();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
